ysyx_22040386_wb_arb: RTL and testbench

Register-file write-port and commit-slot arbiter at the tail of the 5-stage pipeline, right after the WB stage. It shares the single regfile write port and single per-cycle commit slot between the in-order WB stage and the out-of-band multi-cycle unit (MDU: mul/div) result. It holds one MDU result, drains it into idle WB cycles, and stalls the pipeline when the result has waited too long. It also owns the commit stream: pc, instruction, unknown-opcode trap flag and retired-instruction count.

---
 rtl/ysyx_22040386_wb_arb_pkg.sv | 33 +++
 rtl/ysyx_22040386_wb_arb_buf.sv | 30 +++
 rtl/ysyx_22040386_wb_arb.sv | 158 +++++++++++++++
 tb/tb_ysyx_22040386_wb_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040386_wb_arb_pkg.sv
// Shared types for the WB/MDU write-port and commit-slot arbiter.
package ysyx_22040386_wb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_WB   = 2'd1,
      SRC_BUF  = 2'd2,
      SRC_MDU  = 2'd3
   } arb_src_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [63:0] data;
      logic        wen;
      logic        unknown;
   } commit_rec_t;

   localparam int unsigned WAIT_W = 4;

   // x0 is hardwired, so a record only reaches the regfile when rd is non-zero.
   function automatic logic rec_writes(input commit_rec_t rec);
      return rec.wen && (rec.rd != 5'd0);
   endfunction

endpackage

// File: rtl/ysyx_22040386_wb_arb_buf.sv
// One-entry holding register for an MDU result that lost the commit slot.
module ysyx_22040386_wb_buf
   import ysyx_22040386_wb_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        clear_i,
   input  commit_rec_t rec_i,
   output commit_rec_t rec_o
);

   commit_rec_t rec_q;

   // Load has priority; a drained entry is zeroed so stale rd never lingers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_q <= '0;
      end else if (load_i) begin
         rec_q <= rec_i;
      end else if (clear_i) begin
         rec_q <= '0;
      end else begin
         rec_q <= rec_q;
      end
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/ysyx_22040386_wb_arb.sv
// Shares the regfile write port and commit slot between WB and one buffered MDU result.
module ysyx_22040386_wb_arb
   import ysyx_22040386_wb_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_WB_valid,
   input  logic        i_WB_RegWrite,
   input  logic [4:0]  i_WB_reg_wr_addr,
   input  logic [63:0] i_WB_reg_wr_data,
   input  logic [63:0] i_WB_pc,
   input  logic [31:0] i_WB_inst,
   input  logic        i_WB_unkown_code,
   input  logic        i_MDU_valid,
   output logic        o_MDU_ready,
   input  logic [4:0]  i_MDU_rd,
   input  logic [63:0] i_MDU_data,
   input  logic [63:0] i_MDU_pc,
   input  logic [31:0] i_MDU_inst,
   output logic        o_rf_wen,
   output logic [4:0]  o_rf_waddr,
   output logic [63:0] o_rf_wdata,
   output logic        o_commit_valid,
   output logic [63:0] o_commit_pc,
   output logic [31:0] o_commit_inst,
   output logic        o_WB_stall,
   output logic        o_mdu_pend,
   output logic [4:0]  o_mdu_pend_rd,
   output logic        o_trap,
   output logic [63:0] o_commit_cnt
);

   localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

   arb_state_e        state_q;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_inc_s;
   logic              trap_q;
   logic [63:0]       cnt_q;

   arb_src_e    src_s;
   commit_rec_t wb_rec_s;
   commit_rec_t mdu_rec_s;
   commit_rec_t buf_rec_s;
   commit_rec_t win_rec_s;
   logic        commit_valid_s;
   logic        buf_load_s;
   logic        buf_clr_s;

   assign wb_rec_s = '{pc: i_WB_pc, inst: i_WB_inst, rd: i_WB_reg_wr_addr,
                       data: i_WB_reg_wr_data, wen: i_WB_RegWrite,
                       unknown: i_WB_unkown_code};
   assign mdu_rec_s = '{pc: i_MDU_pc, inst: i_MDU_inst, rd: i_MDU_rd,
                        data: i_MDU_data, wen: 1'b1, unknown: 1'b0};

   // Slot owner: a forced drain beats WB, WB beats a waiting buffer, bypass only when idle.
   always_comb begin
      src_s = SRC_NONE;
      if (state_q == ST_FORCE) begin
         src_s = SRC_BUF;
      end else if (i_WB_valid) begin
         src_s = SRC_WB;
      end else if (state_q == ST_HOLD) begin
         src_s = SRC_BUF;
      end else if ((state_q == ST_IDLE) && i_MDU_valid) begin
         src_s = SRC_MDU;
      end else begin
         src_s = SRC_NONE;
      end
   end

   // Route the winning record to the regfile and commit stream.
   always_comb begin
      win_rec_s = '0;
      case (src_s)
         SRC_WB:  win_rec_s = wb_rec_s;
         SRC_BUF: win_rec_s = buf_rec_s;
         SRC_MDU: win_rec_s = mdu_rec_s;
         default: win_rec_s = '0;
      endcase
   end

   assign commit_valid_s = (src_s != SRC_NONE);
   assign buf_load_s     = (state_q == ST_IDLE) && i_MDU_valid && i_WB_valid;
   assign buf_clr_s      = (src_s == SRC_BUF);
   assign wait_inc_s     = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};

   ysyx_22040386_wb_buf u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (buf_load_s),
      .clear_i (buf_clr_s),
      .rec_i   (mdu_rec_s),
      .rec_o   (buf_rec_s)
   );

   // Buffer occupancy FSM with starvation counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= buf_load_s ? ST_HOLD : ST_IDLE;
               wait_q  <= '0;
            end
            ST_HOLD: begin
               if (src_s == SRC_BUF) begin
                  state_q <= ST_IDLE;
                  wait_q  <= '0;
               end else if (wait_inc_s >= LIMIT_C) begin
                  state_q <= ST_FORCE;
                  wait_q  <= wait_inc_s;
               end else begin
                  state_q <= ST_HOLD;
                  wait_q  <= wait_inc_s;
               end
            end
            ST_FORCE: begin
               state_q <= ST_IDLE;
               wait_q  <= '0;
            end
            default: begin
               state_q <= ST_IDLE;
               wait_q  <= '0;
            end
         endcase
      end
   end

   // Retirement bookkeeping: sticky unknown-opcode trap and wrapping retire count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q <= 1'b0;
         cnt_q  <= 64'd0;
      end else begin
         trap_q <= trap_q | (commit_valid_s & win_rec_s.unknown);
         cnt_q  <= commit_valid_s ? cnt_q + 64'd1 : cnt_q;
      end
   end

   assign o_rf_wen       = commit_valid_s & rec_writes(win_rec_s);
   assign o_rf_waddr     = win_rec_s.rd;
   assign o_rf_wdata     = win_rec_s.data;
   assign o_commit_valid = commit_valid_s;
   assign o_commit_pc    = win_rec_s.pc;
   assign o_commit_inst  = win_rec_s.inst;
   assign o_MDU_ready    = (state_q == ST_IDLE);
   assign o_WB_stall     = (state_q == ST_FORCE);
   assign o_mdu_pend     = (state_q != ST_IDLE);
   assign o_mdu_pend_rd  = buf_rec_s.rd;
   assign o_trap         = trap_q;
   assign o_commit_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_22040386_wb_arb.sv
// Scoreboard bench: timestamp-based reference model feeds queues, a negedge monitor compares.
module tb_ysyx_22040386_wb_arb;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_WB_valid = 1'b0, i_WB_RegWrite = 1'b0, i_WB_unkown_code = 1'b0;
   logic [4:0]  i_WB_reg_wr_addr = 5'd0;
   logic [63:0] i_WB_reg_wr_data = 64'd0, i_WB_pc = 64'd0;
   logic [31:0] i_WB_inst = 32'd0;
   logic        i_MDU_valid = 1'b0;
   logic [4:0]  i_MDU_rd = 5'd0;
   logic [63:0] i_MDU_data = 64'd0, i_MDU_pc = 64'd0;
   logic [31:0] i_MDU_inst = 32'd0;
   logic        o_MDU_ready, o_rf_wen, o_commit_valid, o_WB_stall, o_mdu_pend, o_trap;
   logic [4:0]  o_rf_waddr, o_mdu_pend_rd;
   logic [63:0] o_rf_wdata, o_commit_pc, o_commit_cnt;
   logic [31:0] o_commit_inst;

   always #5 clk = ~clk;

   ysyx_22040386_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_WB_valid(i_WB_valid), .i_WB_RegWrite(i_WB_RegWrite),
      .i_WB_reg_wr_addr(i_WB_reg_wr_addr), .i_WB_reg_wr_data(i_WB_reg_wr_data),
      .i_WB_pc(i_WB_pc), .i_WB_inst(i_WB_inst), .i_WB_unkown_code(i_WB_unkown_code),
      .i_MDU_valid(i_MDU_valid), .o_MDU_ready(o_MDU_ready),
      .i_MDU_rd(i_MDU_rd), .i_MDU_data(i_MDU_data), .i_MDU_pc(i_MDU_pc), .i_MDU_inst(i_MDU_inst),
      .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
      .o_commit_valid(o_commit_valid), .o_commit_pc(o_commit_pc), .o_commit_inst(o_commit_inst),
      .o_WB_stall(o_WB_stall), .o_mdu_pend(o_mdu_pend), .o_mdu_pend_rd(o_mdu_pend_rd),
      .o_trap(o_trap), .o_commit_cnt(o_commit_cnt)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        wen;
      logic [4:0]  waddr;
      logic [63:0] wdata;
   } exp_commit_t;

   typedef struct {
      logic        cv;
      logic        stall;
      logic        ready;
      logic        pend;
      logic [4:0]  pend_rd;
      logic        trap;
      logic [63:0] cnt;
   } exp_ctl_t;

   exp_commit_t commit_q[$];
   exp_ctl_t    ctl_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model: the pending MDU result is tracked by its acceptance cycle.
   bit          bq_full = 1'b0;
   int          bq_acc = 0;
   logic [4:0]  bq_rd = 5'd0;
   logic [63:0] bq_data = 64'd0, bq_pc = 64'd0;
   logic [31:0] bq_inst = 32'd0;
   int          cyc_n = 0;
   logic        trap_m = 1'b0;
   logic [63:0] cnt_m = 64'd0;
   bit          last_stall = 1'b0;

   // Offered transactions
   bit          w_valid = 1'b0, w_rw = 1'b0, w_unk = 1'b0;
   logic [4:0]  w_rd = 5'd0;
   logic [63:0] w_data = 64'd0, w_pc = 64'd0;
   logic [31:0] w_inst = 32'd0;
   bit          m_valid = 1'b0;
   logic [4:0]  m_rd = 5'd0;
   logic [63:0] m_data = 64'd0, m_pc = 64'd0;
   logic [31:0] m_inst = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_wb(input bit v, input bit rw, input logic [4:0] rd, input logic [63:0] d,
                         input logic [63:0] pc, input logic [31:0] inst, input bit unk);
      w_valid = v; w_rw = rw; w_rd = rd; w_data = d; w_pc = pc; w_inst = inst; w_unk = unk;
   endtask

   task automatic set_mdu(input logic [4:0] rd, input logic [63:0] d,
                          input logic [63:0] pc, input logic [31:0] inst);
      m_valid = 1'b1; m_rd = rd; m_data = d; m_pc = pc; m_inst = inst;
   endtask

   // One clock: drive, predict, push expectations, advance the model after the edge.
   task automatic step();
      bit          stall, ready;
      int          win;
      exp_commit_t e;
      exp_ctl_t    c;
      i_WB_valid = w_valid; i_WB_RegWrite = w_rw; i_WB_reg_wr_addr = w_rd;
      i_WB_reg_wr_data = w_data; i_WB_pc = w_pc; i_WB_inst = w_inst; i_WB_unkown_code = w_unk;
      i_MDU_valid = m_valid; i_MDU_rd = m_rd; i_MDU_data = m_data;
      i_MDU_pc = m_pc; i_MDU_inst = m_inst;

      stall = bq_full && ((cyc_n - bq_acc) == LIMIT + 1);
      ready = !bq_full;
      if (stall)        win = 2;
      else if (w_valid) win = 1;
      else if (bq_full) win = 2;
      else if (m_valid) win = 3;
      else              win = 0;

      e.pc = 64'd0; e.inst = 32'd0; e.wen = 1'b0; e.waddr = 5'd0; e.wdata = 64'd0;
      if (win == 1) begin
         e.pc = w_pc; e.inst = w_inst; e.waddr = w_rd; e.wdata = w_data;
         e.wen = w_rw && (w_rd != 5'd0);
      end else if (win == 2) begin
         e.pc = bq_pc; e.inst = bq_inst; e.waddr = bq_rd; e.wdata = bq_data;
         e.wen = (bq_rd != 5'd0);
      end else if (win == 3) begin
         e.pc = m_pc; e.inst = m_inst; e.waddr = m_rd; e.wdata = m_data;
         e.wen = (m_rd != 5'd0);
      end
      if (win != 0) commit_q.push_back(e);

      c.cv = (win != 0); c.stall = stall; c.ready = ready; c.pend = bq_full;
      c.pend_rd = bq_rd; c.trap = trap_m; c.cnt = cnt_m;
      ctl_q.push_back(c);

      @(posedge clk);
      #1;
      if (win != 0) cnt_m = cnt_m + 64'd1;
      if (win == 1 && w_unk) trap_m = 1'b1;
      if (win == 2) begin
         bq_full = 1'b0;
      end else if (!bq_full && m_valid && w_valid) begin
         bq_full = 1'b1; bq_acc = cyc_n; bq_rd = m_rd;
         bq_data = m_data; bq_pc = m_pc; bq_inst = m_inst;
      end
      if (m_valid && ready) m_valid = 1'b0;
      last_stall = stall;
      cyc_n++;
   endtask

   task automatic model_reset();
      bq_full = 1'b0; bq_rd = 5'd0; cnt_m = 64'd0; trap_m = 1'b0;
      m_valid = 1'b0; last_stall = 1'b0;
   endtask

   // Called just after a posedge; asserts reset mid-cycle and checks the async response.
   task automatic mid_reset();
      chk("pre_rst_pend", {63'd0, o_mdu_pend}, {63'd0, bq_full});
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_ready", {63'd0, o_MDU_ready}, 64'd1);
      chk("rst_stall", {63'd0, o_WB_stall}, 64'd0);
      chk("rst_pend", {63'd0, o_mdu_pend}, 64'd0);
      chk("rst_trap", {63'd0, o_trap}, 64'd0);
      chk("rst_cnt", o_commit_cnt, 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_ctl_t    c;
      exp_commit_t e;
      forever begin
         @(negedge clk);
         if (ctl_q.size() != 0) begin
            c = ctl_q.pop_front();
            chk("commit_valid", {63'd0, o_commit_valid}, {63'd0, c.cv});
            chk("wb_stall", {63'd0, o_WB_stall}, {63'd0, c.stall});
            chk("mdu_ready", {63'd0, o_MDU_ready}, {63'd0, c.ready});
            chk("mdu_pend", {63'd0, o_mdu_pend}, {63'd0, c.pend});
            if (c.pend) chk("mdu_pend_rd", {59'd0, o_mdu_pend_rd}, {59'd0, c.pend_rd});
            chk("trap", {63'd0, o_trap}, {63'd0, c.trap});
            chk("commit_cnt", o_commit_cnt, c.cnt);
            if (o_commit_valid) begin
               chk("commit_expected", {63'd0, commit_q.size() != 0}, 64'd1);
               if (commit_q.size() != 0) begin
                  e = commit_q.pop_front();
                  chk("commit_pc", o_commit_pc, e.pc);
                  chk("commit_inst", {32'd0, o_commit_inst}, {32'd0, e.inst});
                  chk("rf_wen", {63'd0, o_rf_wen}, {63'd0, e.wen});
                  if (e.wen) begin
                     chk("rf_waddr", {59'd0, o_rf_waddr}, {59'd0, e.waddr});
                     chk("rf_wdata", o_rf_wdata, e.wdata);
                  end
               end
            end
         end
      end
   end

   initial begin : stim
      int prob;
      #3;
      chk("init_ready", {63'd0, o_MDU_ready}, 64'd1);
      chk("init_stall", {63'd0, o_WB_stall}, 64'd0);
      chk("init_cnt", o_commit_cnt, 64'd0);
      chk("init_trap", {63'd0, o_trap}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Bypass
      set_wb(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 1'b0);
      set_mdu(5'd5, 64'h1234, 64'h8000_1000, 32'h02b5_0533);
      step();
      // Drain on idle WB
      set_wb(1'b1, 1'b1, 5'd3, 64'hAAAA, 64'h8000_1004, 32'h0000_0193, 1'b0);
      set_mdu(5'd7, 64'h7777, 64'h8000_0ff0, 32'h02c5_83b3);
      step();
      set_wb(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 1'b0);
      step();
      // Starvation: WB valid every cycle
      set_mdu(5'd9, 64'h9999, 64'h8000_2000, 32'h02d6_04b3);
      for (int i = 0; i < 8; i++) begin
         if (!last_stall)
            set_wb(1'b1, 1'b1, 5'(i + 10), 64'(i * 3 + 1), 64'h8000_3000 + 64'(i * 4),
                   32'h0000_0013 + 32'(i), 1'b0);
         step();
      end
      // x0 write with unknown opcode
      set_wb(1'b1, 1'b1, 5'd0, 64'hDEAD, 64'h8000_4000, 32'hFFFF_FFFF, 1'b1);
      step();
      set_wb(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 1'b0);
      step();
      step();
      // Back-to-back MDU results
      set_wb(1'b1, 1'b1, 5'd4, 64'h44, 64'h8000_5000, 32'h0000_0213, 1'b0);
      set_mdu(5'd12, 64'hC0C0, 64'h8000_4ff0, 32'h02e7_0633);
      step();
      set_wb(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 1'b0);
      set_mdu(5'd13, 64'hD0D0, 64'h8000_4ff4, 32'h02f7_86b3);
      step();
      step();
      // Reset while a result is held
      set_wb(1'b1, 1'b1, 5'd6, 64'h66, 64'h8000_6000, 32'h0000_0313, 1'b0);
      set_mdu(5'd14, 64'hE0E0, 64'h8000_5ff0, 32'h0307_8733);
      step();
      mid_reset();

      // Randomized traffic in phases of different WB density
      for (int p = 0; p < 15; p++) begin
         case (p % 3)
            0:       prob = 30;
            1:       prob = 75;
            default: prob = 100;
         endcase
         for (int i = 0; i < 200; i++) begin
            if (!last_stall)
               set_wb($urandom_range(0, 99) < prob, 1'($urandom), 5'($urandom_range(0, 31)),
                      {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
                      $urandom_range(0, 299) == 0);
            if (!m_valid && ($urandom_range(0, 99) < 40))
               set_mdu(5'($urandom_range(0, 31)), {$urandom, $urandom},
                       {$urandom, $urandom}, $urandom);
            step();
         end
         if (p == 7) mid_reset();
      end

      @(negedge clk);
      chk("commit_q_drained", 64'(commit_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
